n_output_ctrl: RTL and testbench

N_OUTPUT_CTRL -- requirements
Module: n_output_ctrl

---
 rtl/n_output_ctrl.sv | 166 ++++++++++++++++
 tb/tb_n_output_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/n_output_ctrl.sv
// n_output_ctrl: north output-port controller for a 4-input router.
// Turns the arbiter grant into a one-hot dequeue strobe, holds the output
// for a multi-flit packet until its tail, and tracks downstream credits.
// Optional build macro: N_OUTPUT_CTRL_ERR_EN enables the sticky protocol-error
// flag (credit return at full count, or a non-one-hot grant while idle).
// Port bit order everywhere: s,w,e,l = [3:0].
module n_output_ctrl #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       grant_i,
  input  logic [3:0]       in_valid_i,
  input  logic [3:0]       in_tail_i,
  input  logic             credit_return_i,
  output logic             credit_avail_o,
  output logic             change_order_o,
  output logic [3:0]       send_o,
  output logic [3:0]       lock_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [3:0]       lock_r;
  logic [CNT_W-1:0] credit_cnt_r;
  logic [3:0]       send_s;
  logic             send_any_s;
  logic             sent_tail_s;
  logic             credit_ok_s;

  // True when exactly one bit of the 4-bit vector is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  assign credit_ok_s = (credit_cnt_r != CNT_ZERO);
  assign send_any_s  = |send_s;
  assign sent_tail_s = |(send_s & in_tail_i);

  // Output decode: choose which input buffer (if any) is dequeued this cycle.
  always_comb begin
    send_s = 4'b0000;
    if (!reset) begin
      // Reset also masks the zero-latency strobe, not only the registers.
      send_s = 4'b0000;
    end else if (state_r == IDLE) begin
      if (is_one_hot(grant_i) && (|(grant_i & in_valid_i)) && credit_ok_s) begin
        send_s = grant_i;
      end else begin
        send_s = 4'b0000;
      end
    end else begin
      // Grant is ignored while a packet holds the output.
      if ((|(lock_r & in_valid_i)) && credit_ok_s) begin
        send_s = lock_r;
      end else begin
        send_s = 4'b0000;
      end
    end
  end

  // Next-state logic: a non-tail send opens a packet, a tail send closes it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (send_any_s && !sent_tail_s) begin
          state_next_s = LOCKED;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOCKED: begin
        if (send_any_s && sent_tail_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Lock register: remembers the port owning the output during a packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_r <= 4'b0000;
    end else if (send_any_s && !sent_tail_s) begin
      lock_r <= send_s;
    end else if (send_any_s && sent_tail_s) begin
      lock_r <= 4'b0000;
    end else begin
      lock_r <= lock_r;
    end
  end

  // Credit counter: send consumes, return refunds, saturating at full depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_cnt_r <= CNT_FULL;
    end else begin
      case ({send_any_s, credit_return_i})
        2'b10: credit_cnt_r <= credit_cnt_r - CNT_ONE;
        2'b01: begin
          if (credit_cnt_r != CNT_FULL) begin
            credit_cnt_r <= credit_cnt_r + CNT_ONE;
          end else begin
            credit_cnt_r <= credit_cnt_r;
          end
        end
        default: credit_cnt_r <= credit_cnt_r;
      endcase
    end
  end

`ifdef N_OUTPUT_CTRL_ERR_EN
  logic err_r;
  logic err_hit_s;

  assign err_hit_s = (credit_return_i && (credit_cnt_r == CNT_FULL)) ||
                     ((state_r == IDLE) && (grant_i != 4'b0000) && !is_one_hot(grant_i));

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (err_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

  assign credit_avail_o = (state_r == IDLE) && credit_ok_s;
  assign change_order_o = sent_tail_s;
  assign send_o         = send_s;
  assign lock_o         = lock_r;
  assign credit_cnt_o   = credit_cnt_r;

endmodule

// File: tb/tb_n_output_ctrl.sv
// Self-checking bench for n_output_ctrl: directed scenarios plus a randomized
// run compared against a port-index / integer-credit reference model.
module tb_n_output_ctrl;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef N_OUTPUT_CTRL_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    grant, valid, tail;
  logic          ret;
  logic          avail, change, err;
  logic [3:0]    send, lock;
  logic [CW-1:0] cnt;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  n_output_ctrl #(.CREDIT_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .grant_i(grant), .in_valid_i(valid),
    .in_tail_i(tail), .credit_return_i(ret), .credit_avail_o(avail),
    .change_order_o(change), .send_o(send), .lock_o(lock),
    .credit_cnt_o(cnt), .err_o(err)
  );

  task automatic set_in(input logic [3:0] g, input logic [3:0] v,
                        input logic [3:0] t, input logic r);
    grant = g; valid = v; tail = t; ret = r;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(4'b0100, 4'b0100, 4'b0100, 1'b0);
    next_cycle();
    tests++; if (send !== 4'b0000) begin fails++; $display("FAIL rst_send: got %b expected 0000", send); end
    tests++; if (change !== 1'b0) begin fails++; $display("FAIL rst_change: got %b expected 0", change); end
    tests++; if (lock !== 4'b0000) begin fails++; $display("FAIL rst_lock: got %b expected 0000", lock); end
    tests++; if (cnt !== 3'd4) begin fails++; $display("FAIL rst_cnt: got %0d expected 4", cnt); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_flit();
    do_reset();
    set_in(4'b0100, 4'b0100, 4'b0100, 1'b0);
    @(negedge clk);
    tests++; if (send !== 4'b0100) begin fails++; $display("FAIL sf_send: got %b expected 0100", send); end
    tests++; if (change !== 1'b1) begin fails++; $display("FAIL sf_change: got %b expected 1", change); end
    next_cycle();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tests++; if (cnt !== 3'd3) begin fails++; $display("FAIL sf_cnt: got %0d expected 3", cnt); end
    tests++; if (lock !== 4'b0000) begin fails++; $display("FAIL sf_lock: got %b expected 0000", lock); end
    tests++; if (avail !== 1'b1) begin fails++; $display("FAIL sf_idle: got %b expected 1", avail); end
  endtask

  task automatic test_multi_flit();
    logic [3:0] exp_lock [3];
    logic [3:0] exp_tail [3];
    exp_lock = '{4'b1000, 4'b1000, 4'b0000};
    exp_tail = '{4'b0000, 4'b0100, 4'b1100};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      // First flit granted to s; afterwards a w grant is injected.
      set_in((i == 0) ? 4'b1000 : 4'b0100, 4'b1100, exp_tail[i], 1'b0);
      @(negedge clk);
      tests++; if (send !== 4'b1000) begin fails++; $display("FAIL mf_send%0d: got %b expected 1000", i, send); end
      tests++; if (change !== (i == 2)) begin fails++; $display("FAIL mf_change%0d: got %b expected %b", i, change, (i == 2)); end
      next_cycle();
      tests++; if (lock !== exp_lock[i]) begin fails++; $display("FAIL mf_lock%0d: got %b expected %b", i, lock, exp_lock[i]); end
      tests++; if (cnt !== CW'(3 - i)) begin fails++; $display("FAIL mf_cnt%0d: got %0d expected %0d", i, cnt, 3 - i); end
    end
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_credit_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(4'b0001, 4'b0001, 4'b0000, 1'b0);
      @(negedge clk);
      tests++; if (send !== 4'b0001) begin fails++; $display("FAIL dr_send%0d: got %b expected 0001", i, send); end
      next_cycle();
      tests++; if (cnt !== CW'(3 - i)) begin fails++; $display("FAIL dr_cnt%0d: got %0d expected %0d", i, cnt, 3 - i); end
    end
    set_in(4'b0001, 4'b0001, 4'b0000, 1'b1);
    @(negedge clk);
    tests++; if (send !== 4'b0000) begin fails++; $display("FAIL dr_stall_send: got %b expected 0000", send); end
    tests++; if (avail !== 1'b0) begin fails++; $display("FAIL dr_avail: got %b expected 0", avail); end
    tests++; if (lock !== 4'b0001) begin fails++; $display("FAIL dr_lock: got %b expected 0001", lock); end
    next_cycle();
    tests++; if (cnt !== 3'd1) begin fails++; $display("FAIL dr_ret_cnt: got %0d expected 1", cnt); end
    set_in(4'b0000, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    tests++; if (send !== 4'b0001) begin fails++; $display("FAIL dr_resend: got %b expected 0001", send); end
    next_cycle();
    tests++; if (cnt !== 3'd0) begin fails++; $display("FAIL dr_cnt_end: got %0d expected 0", cnt); end
    @(negedge clk);
    tests++; if (send !== 4'b0000) begin fails++; $display("FAIL dr_end_send: got %b expected 0000", send); end
    next_cycle();
  endtask

  task automatic test_simul_return();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(4'b0100, 4'b0100, 4'b0100, (i == 2));
      @(negedge clk);
      tests++; if (send !== 4'b0100) begin fails++; $display("FAIL sr_send%0d: got %b expected 0100", i, send); end
      next_cycle();
    end
    tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL sr_cnt: got %0d expected 2", cnt); end
    do_reset();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b1);
    next_cycle();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tests++; if (cnt !== 3'd4) begin fails++; $display("FAIL sat_cnt: got %0d expected 4", cnt); end
    tests++; if (err !== ERR_ON) begin fails++; $display("FAIL sat_err: got %b expected %b", err, ERR_ON); end
  endtask

  task automatic test_bad_grant();
    do_reset();
    set_in(4'b0011, 4'b0011, 4'b0011, 1'b0);
    @(negedge clk);
    tests++; if (send !== 4'b0000) begin fails++; $display("FAIL bg_send: got %b expected 0000", send); end
    tests++; if (change !== 1'b0) begin fails++; $display("FAIL bg_change: got %b expected 0", change); end
    next_cycle();
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    tests++; if (cnt !== 3'd4) begin fails++; $display("FAIL bg_cnt: got %0d expected 4", cnt); end
    tests++; if (lock !== 4'b0000) begin fails++; $display("FAIL bg_lock: got %b expected 0000", lock); end
    tests++; if (avail !== 1'b1) begin fails++; $display("FAIL bg_idle: got %b expected 1", avail); end
    tests++; if (err !== ERR_ON) begin fails++; $display("FAIL bg_err: got %b expected %b", err, ERR_ON); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_in(4'b0010, 4'b0010, 4'b0000, 1'b0);
    next_cycle();
    next_cycle();
    tests++; if (lock !== 4'b0010) begin fails++; $display("FAIL rm_lock_pre: got %b expected 0010", lock); end
    tests++; if (cnt !== 3'd2) begin fails++; $display("FAIL rm_cnt_pre: got %0d expected 2", cnt); end
    reset = 1'b0;
    #1;
    tests++; if (lock !== 4'b0000) begin fails++; $display("FAIL rm_lock: got %b expected 0000", lock); end
    tests++; if (cnt !== 3'd4) begin fails++; $display("FAIL rm_cnt: got %0d expected 4", cnt); end
    tests++; if (send !== 4'b0000) begin fails++; $display("FAIL rm_send: got %b expected 0000", send); end
    reset = 1'b1;
    set_in(4'b0001, 4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    tests++; if (send !== 4'b0001) begin fails++; $display("FAIL rm_new_send: got %b expected 0001", send); end
    tests++; if (change !== 1'b1) begin fails++; $display("FAIL rm_new_change: got %b expected 1", change); end
    next_cycle();
    tests++; if (cnt !== 3'd3) begin fails++; $display("FAIL rm_new_cnt: got %0d expected 3", cnt); end
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    int         lk;      // port index owning the output, -1 when free
    int         cr;      // downstream credits held
    logic       er;
    int         p;
    int         r;
    logic [3:0] exp_send, exp_lock;
    logic       exp_change, exp_avail, sent;
    do_reset();
    lk = -1; cr = DEPTH; er = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 19);
      if (r < 13)      grant = 4'(1 << $urandom_range(0, 3));
      else if (r < 18) grant = 4'b0000;
      else             grant = 4'($urandom_range(0, 15));
      valid = 4'($urandom_range(0, 15));
      tail  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if (cr < DEPTH) ret = ($urandom_range(0, 2) == 0);
      else            ret = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      p = -1;
      if (lk < 0) begin
        if ($countones(grant) == 1)
          for (int i = 0; i < 4; i++) if (grant[i]) p = i;
      end else begin
        p = lk;
      end
      sent = (p >= 0) && valid[p] && (cr > 0);
      exp_send   = sent ? 4'(1 << p) : 4'b0000;
      exp_change = sent && tail[p];
      exp_avail  = (lk < 0) && (cr > 0);
      exp_lock   = (lk < 0) ? 4'b0000 : 4'(1 << lk);
      tests++; if (send !== exp_send) begin fails++; $display("FAIL rnd_send c%0d: got %b expected %b", c, send, exp_send); end
      tests++; if (change !== exp_change) begin fails++; $display("FAIL rnd_change c%0d: got %b expected %b", c, change, exp_change); end
      tests++; if (avail !== exp_avail) begin fails++; $display("FAIL rnd_avail c%0d: got %b expected %b", c, avail, exp_avail); end
      tests++; if (lock !== exp_lock) begin fails++; $display("FAIL rnd_lock c%0d: got %b expected %b", c, lock, exp_lock); end
      tests++; if (cnt !== CW'(cr)) begin fails++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, cnt, cr); end
      tests++; if (err !== er) begin fails++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err, er); end
      if (ERR_ON && ((ret && cr == DEPTH) || (lk < 0 && grant != 4'b0000 && $countones(grant) != 1)))
        er = 1'b1;
      if (sent && !ret)      cr = cr - 1;
      else if (!sent && ret) cr = (cr < DEPTH) ? cr + 1 : DEPTH;
      if (sent) lk = tail[p] ? -1 : p;
      next_cycle();
    end
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
  endtask

  initial begin
    set_in(4'b0000, 4'b0000, 4'b0000, 1'b0);
    test_reset();
    test_single_flit();
    test_multi_flit();
    test_credit_drain();
    test_simul_return();
    test_bad_grant();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
